pixel_reader_fifo: RTL and testbench

- Parametrised successor to the single-register pixel reader.
- Captures pixels on `enable` into a small FIFO and presents them on `saida_conduit` with a valid/ready handshake, so a slow consumer no longer loses pixels.
- Keeps the `done` acknowledge toward the Avalon-side writer.
- Sits between the pixel source (DMA/slave write) and the processing conduit of the embedded system.

---
 rtl/pixel_reader_fifo.sv | 133 +++++++++++++
 tb/tb_pixel_reader_fifo.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_reader_fifo.sv
// rtl/pixel_reader_fifo.sv - pixel capture FIFO with valid/ready output and done ack
//
// Purpose:
//   Captures pixels offered on `enable` into a small show-ahead FIFO and
//   presents the oldest one on `saida_conduit` with a valid/ready handshake,
//   so a slow consumer no longer loses pixels. `done` acknowledges every
//   accepted write one cycle later, toward the Avalon-side writer.
//
// Parameters:
//   DATA_W  pixel width in bits
//   DEPTH   FIFO entries, power of two, >= 2
//   CNT_W   width of `count`, equals log2(DEPTH)+1
//
// Ports:
//   clock          in   system clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   enable         in   write strobe, pixel offered this cycle
//   pixel          in   pixel data sampled when enable=1
//   saida_conduit  out  head-of-FIFO pixel, 0 while empty
//   saida_valid    out  FIFO non-empty
//   saida_ready    in   consumer accepts the head this cycle
//   done           out  registered ack of the previous-cycle accepted write
//   full           out  count == DEPTH
//   count          out  occupancy 0..DEPTH
//   overflow       out  sticky rejected-write flag (only with PIXEL_READER_OVF_EN)
//
// Build option:
//   PIXEL_READER_OVF_EN  adds the `overflow` port; without it rejected writes
//                        are silently dropped.

module pixel_reader_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [DATA_W-1:0] pixel,
  output logic [DATA_W-1:0] saida_conduit,
  output logic              saida_valid,
  input  logic              saida_ready,
  output logic              done,
  output logic              full,
  output logic [CNT_W-1:0]  count
`ifdef PIXEL_READER_OVF_EN
  ,
  output logic              overflow
`endif
);

  // Pointers are one bit narrower than the occupancy counter, so they wrap
  // naturally from DEPTH-1 to 0 without explicit compare logic.
  localparam int             PTR_W   = CNT_W - 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Storage has no reset: contents are only observable through rd_ptr while
  // count is non-zero, and count itself is reset.
  logic [DATA_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  logic pop;
  logic push;
  logic rejected;

  // Flags are decoded straight from the registered count, so they move on
  // the same edge as count and clear immediately on an asynchronous reset.
  assign saida_valid = (count != '0);
  assign full        = (count == DEPTH_C);

  // Show-ahead output: the head entry is presented as soon as it is written.
  // Forced to zero while empty so stale memory never leaks to the consumer.
  assign saida_conduit = saida_valid ? mem[rd_ptr] : '0;

  // A write into a full FIFO is still accepted when the head leaves in the
  // same cycle; that slot is the one being freed.
  assign pop      = saida_valid & saida_ready;
  assign push     = enable & (~full | pop);
  assign rejected = enable & full & ~pop;

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= pixel;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      done   <= 1'b0;
    end else begin
      done <= push;

      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end

      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end

      // Simultaneous push and pop leaves occupancy unchanged.
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

`ifdef PIXEL_READER_OVF_EN
  // Sticky until reset so software can detect that any pixel was ever lost.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (rejected) begin
      overflow <= 1'b1;
    end
  end
`else
  // Without the flag a rejected write just disappears; the term is kept so
  // both builds share the same acceptance logic.
  logic unused_rejected;
  assign unused_rejected = rejected;
`endif

endmodule

// File: tb/tb_pixel_reader_fifo.sv
// tb/tb_pixel_reader_fifo.sv - scoreboard bench for pixel_reader_fifo

module tb_pixel_reader_fifo;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 3;

  logic              clock;
  logic              reset_n;
  logic              enable;
  logic [DATA_W-1:0] pixel;
  logic [DATA_W-1:0] saida_conduit;
  logic              saida_valid;
  logic              saida_ready;
  logic              done;
  logic              full;
  logic [CNT_W-1:0]  count;
`ifdef PIXEL_READER_OVF_EN
  logic              overflow;
`endif

  pixel_reader_fifo #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .enable       (enable),
    .pixel        (pixel),
    .saida_conduit(saida_conduit),
    .saida_valid  (saida_valid),
    .saida_ready  (saida_ready),
    .done         (done),
    .full         (full),
    .count        (count)
`ifdef PIXEL_READER_OVF_EN
    ,
    .overflow     (overflow)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Scoreboard: pixels the reference expects to be queued, oldest first.
  logic [DATA_W-1:0] sb_q[$];
  logic              m_done = 1'b0;
  logic              m_ovf  = 1'b0;

  // Called just after a falling edge. Drives inputs, compares any popped
  // head against the scoreboard, advances the reference, then moves to the
  // next falling edge.
  task automatic step(input logic en, input logic [DATA_W-1:0] px, input logic rdy);
    logic              m_pop;
    logic              m_push;
    logic [DATA_W-1:0] exp_px;
    enable      = en;
    pixel       = px;
    saida_ready = rdy;
    #1;
    m_pop  = (sb_q.size() != 0) && rdy;
    m_push = en && ((sb_q.size() != DEPTH) || m_pop);
    if (m_pop) begin
      exp_px = sb_q.pop_front();
      checks++;
      if (saida_valid !== 1'b1 || saida_conduit !== exp_px) begin
        errors++;
        $display("FAIL pop_data: got valid=%b data=%h, want valid=1 data=%h",
                 saida_valid, saida_conduit, exp_px);
      end
    end
    if (m_push) sb_q.push_back(px);
    if (en && !m_push) m_ovf = 1'b1;
    m_done = m_push;
    @(posedge clock);
    @(negedge clock);
    enable = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2 && sb_q.size() != 0; i++) step(1'b0, '0, 1'b1);
    checks++;
    if (saida_valid !== 1'b0 || count !== '0 || saida_conduit !== '0) begin
      errors++;
      $display("FAIL drain_empty: got valid=%b count=%0d data=%h, want 0 0 0",
               saida_valid, count, saida_conduit);
    end
  endtask

  task automatic test_reset();
    enable = 1'b0; pixel = '0; saida_ready = 1'b1; reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, '0, 1'b1);
      checks++;
      if (saida_valid !== 1'b0 || count !== '0 || done !== 1'b0 ||
          saida_conduit !== '0 || full !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle[%0d]: got valid=%b count=%0d done=%b full=%b data=%h, want all 0",
                 i, saida_valid, count, done, full, saida_conduit);
      end
    end
  endtask

  task automatic test_single();
    step(1'b1, 32'hDEADBEEF, 1'b0);
    checks++;
    if (done !== 1'b1 || saida_valid !== 1'b1 || saida_conduit !== 32'hDEADBEEF || count !== 3'd1) begin
      errors++;
      $display("FAIL single_write: got done=%b valid=%b data=%h count=%0d, want 1 1 deadbeef 1",
               done, saida_valid, saida_conduit, count);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, 1'b0);
      checks++;
      if (done !== 1'b0 || saida_conduit !== 32'hDEADBEEF || count !== 3'd1) begin
        errors++;
        $display("FAIL single_hold[%0d]: got done=%b data=%h count=%0d, want 0 deadbeef 1",
                 i, done, saida_conduit, count);
      end
    end
    drain();
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= DEPTH; i++) step(1'b1, DATA_W'(i), 1'b0);
    checks++;
    if (full !== 1'b1 || count !== 3'd4 || done !== 1'b1) begin
      errors++;
      $display("FAIL fill: got full=%b count=%0d done=%b, want 1 4 1", full, count, done);
    end
    step(1'b1, 32'h5, 1'b0);
    checks++;
    if (done !== m_done || done !== 1'b0 || full !== 1'b1 || count !== 3'd4) begin
      errors++;
      $display("FAIL reject: got done=%b full=%b count=%0d, want 0 1 4", done, full, count);
    end
`ifdef PIXEL_READER_OVF_EN
    checks++;
    if (overflow !== m_ovf || overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_set: got %b, want 1", overflow);
    end
`endif
    drain();
  endtask

  task automatic test_full_pop_push();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h10 + DATA_W'(i), 1'b0);
    step(1'b1, 32'hA5, 1'b1);
    checks++;
    if (done !== 1'b1 || count !== 3'd4 || full !== 1'b1) begin
      errors++;
      $display("FAIL full_pop_push: got done=%b count=%0d full=%b, want 1 4 1", done, count, full);
    end
`ifdef PIXEL_READER_OVF_EN
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky: got %b, want 1", overflow);
    end
`endif
    drain();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, DATA_W'(i), 1'b1);
      checks++;
      if (done !== 1'b1 || count !== 3'd1 || saida_conduit !== DATA_W'(i)) begin
        errors++;
        $display("FAIL stream[%0d]: got done=%b count=%0d data=%h, want 1 1 %h",
                 i, done, count, saida_conduit, i);
      end
    end
    drain();
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 3; i++) step(1'b1, 32'hC0 + DATA_W'(i), 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (count !== '0 || saida_valid !== 1'b0 || done !== 1'b0 || saida_conduit !== '0) begin
      errors++;
      $display("FAIL async_reset: got count=%0d valid=%b done=%b data=%h, want all 0",
               count, saida_valid, done, saida_conduit);
    end
    sb_q.delete();
    m_done = 1'b0;
    m_ovf  = 1'b0;
    enable = 1'b1;
    pixel  = 32'hBAD;
    @(posedge clock);
    @(negedge clock);
    checks++;
    if (count !== '0 || done !== 1'b0) begin
      errors++;
      $display("FAIL enable_in_reset: got count=%0d done=%b, want 0 0", count, done);
    end
`ifdef PIXEL_READER_OVF_EN
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_reset: got %b, want 0", overflow);
    end
`endif
    enable  = 1'b0;
    reset_n = 1'b1;
    @(negedge clock);
    step(1'b1, 32'h77, 1'b0);
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_full_pop_push();
    test_back_to_back();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
